dag_log_arbiter: RTL

DAG_LOG_ARBITER -- requirements
Module: dag_log_arbiter

---
 rtl/dag_arb_pkg.sv | 36 +++
 rtl/dag_arb_rr_pick.sv | 35 +++
 rtl/dag_log_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dag_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dag_arb_pkg
// Purpose  : Shared constants and types for the dag_log_arbiter slice:
//            requester count, logic opcodes, pipeline FSM state encoding and
//            a one-hot to index helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dag_arb_pkg;

    localparam int NREQ = 4;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    // RUN: pipeline may advance; HOLD: a result is waiting on the consumer.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Index of the set bit of a one-hot vector (0 when the vector is zero).
    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dag_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : dag_arb_rr_pick
// Purpose  : Rotating-priority search. Requests are scanned starting at
//            index ptr and wrapping modulo NREQ; the first asserted request
//            wins.
// Ports    : req [NREQ] in  - request vector
//            ptr [2]    in  - index with highest priority this cycle
//            gnt [NREQ] out - one-hot winner (zero when req is zero)
//            any        out - at least one request is asserted
// Revision : 1.0 - initial release
// ============================================================================
module dag_arb_rr_pick
    import dag_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic            any
);

    // The 2-bit sum wraps naturally, giving the modulo-4 scan order.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[ptr + k[1:0]]) begin
                gnt[ptr + k[1:0]] = 1'b1;
                any               = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dag_log_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dag_log_arbiter
// Purpose  : Four requesters share one 2-stage logic pipeline (AND/OR/XOR/
//            XNOR) through a round-robin arbiter. Stage 1 captures the
//            granted operands, stage 2 holds the result until the consumer
//            accepts it. A back-pressured result freezes both stages and
//            suppresses new grants.
// Ports    : clock            in  - clock, rising edge
//            resetn           in  - synchronous active-low reset
//            req[4]           in  - per-requester request, held until granted
//            a_in/b_in[4*BITS]in  - operands, requester i at [i*BITS +: BITS]
//            op_in[8]         in  - opcode, requester i at [2i +: 2]
//            gnt[4]           out - combinational one-hot/zero grant
//            out_valid        out - result valid
//            out_ready        in  - consumer accepts result
//            out_data[BITS]   out - result
//            out_tag[2]       out - requester index of out_data
//            issue_cnt[16]    out - accepted-request counter
// Config   : DAG_ARB_ISSUE_CNT_EN - when defined, issue_cnt counts accepted
//            grants (wrapping at 16 bits); otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dag_log_arbiter
    import dag_arb_pkg::*;
#(
    parameter int BITS = 2
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BITS-1:0] a_in,
    input  logic [NREQ*BITS-1:0] b_in,
    input  logic [2*NREQ-1:0]    op_in,
    output logic [NREQ-1:0]      gnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITS-1:0]      out_data,
    output logic [1:0]           out_tag,
    output logic [15:0]          issue_cnt
);

    state_t          r_state;
    state_t          w_state_next;
    logic            w_advance;
    logic            w_grant;
    logic [NREQ-1:0] w_pick_gnt;
    logic            w_pick_any;
    logic [1:0]      w_gnt_idx;
    logic [1:0]      r_ptr;

    logic            r_s1_valid;
    logic [BITS-1:0] r_s1_a;
    logic [BITS-1:0] r_s1_b;
    logic [1:0]      r_s1_op;
    logic [1:0]      r_s1_tag;
    logic [BITS-1:0] w_result;

    logic            r_s2_valid;
    logic [BITS-1:0] r_s2_data;
    logic [1:0]      r_s2_tag;

    dag_arb_rr_pick u_pick (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .any (w_pick_any)
    );

    // HOLD is only ever entered with stage 2 valid and keeps it valid, so
    // in HOLD the advance condition reduces to out_ready alone.
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b1;
        case (r_state)
            RUN: begin
                w_advance = !r_s2_valid || out_ready;
                if (r_s2_valid && !out_ready) w_state_next = HOLD;
            end
            HOLD: begin
                w_advance = out_ready;
                if (out_ready) w_state_next = RUN;
            end
            default: w_state_next = RUN;
        endcase
    end

    // No grant may be issued while in reset or while the pipeline is frozen.
    assign w_grant   = resetn && w_advance && w_pick_any;
    assign gnt       = (resetn && w_advance) ? w_pick_gnt : '0;
    assign w_gnt_idx = onehot_to_idx(w_pick_gnt);

    always_comb begin
        w_result = '0;
        case (r_s1_op)
            OP_AND:  w_result = r_s1_a & r_s1_b;
            OP_OR:   w_result = r_s1_a | r_s1_b;
            OP_XOR:  w_result = r_s1_a ^ r_s1_b;
            OP_XNOR: w_result = ~(r_s1_a ^ r_s1_b);
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= RUN;
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_tag   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) r_ptr <= w_gnt_idx + 2'd1;
            if (w_advance) begin
                r_s1_valid <= w_pick_any;
                if (w_pick_any) begin
                    r_s1_a   <= a_in[w_gnt_idx*BITS +: BITS];
                    r_s1_b   <= b_in[w_gnt_idx*BITS +: BITS];
                    r_s1_op  <= op_in[w_gnt_idx*2 +: 2];
                    r_s1_tag <= w_gnt_idx;
                end
                r_s2_valid <= r_s1_valid;
                r_s2_tag   <= r_s1_tag;
                r_s2_data  <= w_result;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_tag   = r_s2_tag;

`ifdef DAG_ARB_ISSUE_CNT_EN
    logic [15:0] r_issue_cnt;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_issue_cnt <= '0;
        end else if (w_grant) begin
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    assign issue_cnt = r_issue_cnt;
`else
    assign issue_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
